// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: datapath widths, the "no producer" label,
// opcode encodings and the label block owned by each functional-unit class.
package tomasulo_pkg;

   localparam int DATA_W     = 32;
   localparam int LABEL_W    = 4;
   localparam int OP_W       = 3;
   localparam int LABEL_NONE = 0;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SLL = 3'd5,
      OP_SRL = 3'd6,
      OP_MUL = 3'd7
   } opcode_e;

   // Each unit class owns a contiguous label range; label 0 is never used.
   localparam int BASE_LABEL_ALU = 1;
   localparam int BASE_LABEL_MUL = 4;
   localparam int BASE_LABEL_MEM = 7;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: holds an instruction and its operands,
// capturing pending operands from the CDB at issue (bypass) or while waiting.
module rs_entry #(
   parameter int DATA_W  = 32,
   parameter int LABEL_W = 4,
   parameter int OP_W    = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               alloc,
   input  logic               free,
   input  logic [OP_W-1:0]    issue_op,
   input  logic [DATA_W-1:0]  issue_vj,
   input  logic [LABEL_W-1:0] issue_qj,
   input  logic [DATA_W-1:0]  issue_vk,
   input  logic [LABEL_W-1:0] issue_qk,
   input  logic               cdb_valid,
   input  logic [LABEL_W-1:0] cdb_label,
   input  logic [DATA_W-1:0]  cdb_data,
   output logic               busy,
   output logic               ready,
   output logic [OP_W-1:0]    op,
   output logic [DATA_W-1:0]  vj,
   output logic [DATA_W-1:0]  vk
);

   logic [LABEL_W-1:0] qj;
   logic [LABEL_W-1:0] qk;
   logic               cdb_hit;

   // A zero label on the bus carries no producer and must never match.
   assign cdb_hit = cdb_valid && (cdb_label != '0);
   assign ready   = busy && (qj == '0) && (qk == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         op   <= '0;
         vj   <= '0;
         qj   <= '0;
         vk   <= '0;
         qk   <= '0;
      end else if (alloc) begin
         busy <= 1'b1;
         op   <= issue_op;
         if (cdb_hit && (issue_qj == cdb_label)) begin
            vj <= cdb_data;
            qj <= '0;
         end else begin
            vj <= issue_vj;
            qj <= issue_qj;
         end
         if (cdb_hit && (issue_qk == cdb_label)) begin
            vk <= cdb_data;
            qk <= '0;
         end else begin
            vk <= issue_vk;
            qk <= issue_qk;
         end
      end else begin
         if (free) begin
            busy <= 1'b0;
         end
         if (busy && cdb_hit && (qj == cdb_label)) begin
            vj <= cdb_data;
            qj <= '0;
         end
         if (busy && cdb_hit && (qk == cdb_label)) begin
            vk <= cdb_data;
            qk <= '0;
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// Reservation station for one functional-unit class: allocates the lowest free
// slot to issued instructions and offers the lowest ready slot to the unit.
module reservation_station #(
   parameter int DEPTH      = 3,
   parameter int BASE_LABEL = 1,
   parameter int DATA_W     = tomasulo_pkg::DATA_W,
   parameter int LABEL_W    = tomasulo_pkg::LABEL_W,
   parameter int OP_W       = tomasulo_pkg::OP_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               issue_valid,
   input  logic [OP_W-1:0]    issue_op,
   input  logic [DATA_W-1:0]  issue_vj,
   input  logic [LABEL_W-1:0] issue_qj,
   input  logic [DATA_W-1:0]  issue_vk,
   input  logic [LABEL_W-1:0] issue_qk,
   output logic               issue_ready,
   output logic [LABEL_W-1:0] issue_label,
   input  logic               cdb_valid,
   input  logic [LABEL_W-1:0] cdb_label,
   input  logic [DATA_W-1:0]  cdb_data,
   output logic               fu_valid,
   input  logic               fu_ready,
   output logic [OP_W-1:0]    fu_op,
   output logic [DATA_W-1:0]  fu_a,
   output logic [DATA_W-1:0]  fu_b,
   output logic [LABEL_W-1:0] fu_label,
   output logic [3:0]         busy_count
);

   import tomasulo_pkg::*;

   logic [DEPTH-1:0]  busy_vec;
   logic [DEPTH-1:0]  ready_vec;
   logic [DEPTH-1:0]  free_sel;
   logic [DEPTH-1:0]  ready_sel;
   logic [DEPTH-1:0]  alloc_vec;
   logic [DEPTH-1:0]  free_vec;
   logic [OP_W-1:0]   op_arr [DEPTH];
   logic [DATA_W-1:0] vj_arr [DEPTH];
   logic [DATA_W-1:0] vk_arr [DEPTH];
   logic              issue_fire;
   logic              fu_fire;

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      rs_entry #(
         .DATA_W  (DATA_W),
         .LABEL_W (LABEL_W),
         .OP_W    (OP_W)
      ) u_entry (
         .clk       (clk),
         .rst       (rst),
         .alloc     (alloc_vec[i]),
         .free      (free_vec[i]),
         .issue_op  (issue_op),
         .issue_vj  (issue_vj),
         .issue_qj  (issue_qj),
         .issue_vk  (issue_vk),
         .issue_qk  (issue_qk),
         .cdb_valid (cdb_valid),
         .cdb_label (cdb_label),
         .cdb_data  (cdb_data),
         .busy      (busy_vec[i]),
         .ready     (ready_vec[i]),
         .op        (op_arr[i]),
         .vj        (vj_arr[i]),
         .vk        (vk_arr[i])
      );
   end

   // Free-slot encoder: scanning downward lets the lowest free index win.
   always_comb begin
      free_sel    = '0;
      issue_ready = 1'b0;
      issue_label = LABEL_W'(LABEL_NONE);
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy_vec[i]) begin
            free_sel    = '0;
            free_sel[i] = 1'b1;
            issue_ready = 1'b1;
            issue_label = LABEL_W'(BASE_LABEL + i);
         end
      end
   end

   // Ready-slot encoder and output mux; outputs are forced to 0 when idle.
   always_comb begin
      ready_sel = '0;
      fu_valid  = 1'b0;
      fu_op     = '0;
      fu_a      = '0;
      fu_b      = '0;
      fu_label  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ready_vec[i]) begin
            ready_sel    = '0;
            ready_sel[i] = 1'b1;
            fu_valid     = 1'b1;
            fu_op        = op_arr[i];
            fu_a         = vj_arr[i];
            fu_b         = vk_arr[i];
            fu_label     = LABEL_W'(BASE_LABEL + i);
         end
      end
   end

   // Both ports move data only on valid && ready at a rising edge; valid never
   // depends on ready, and an un-accepted offer may only be replaced by a
   // lower-index entry that became ready.
   assign issue_fire = issue_valid && issue_ready;
   assign fu_fire    = fu_valid && fu_ready;
   assign alloc_vec  = issue_fire ? free_sel : '0;
   assign free_vec   = fu_fire ? ready_sel : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_count <= '0;
      end else begin
         busy_count <= busy_count + {3'b000, issue_fire} - {3'b000, fu_fire};
      end
   end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Consumer end of the common data bus (CDB). The CDB arbiter selects one producer and broadcasts {label, data}; this block snoops that broadcast.
- It holds DEPTH instruction entries for one functional-unit class and captures pending source operands when their producer label appears on the CDB.
- It hands fully-ready instructions to its functional unit over a valid/ready handshake.
- It sits between the issue/dispatch stage and one functional unit, one instance per unit class.

Parameters:
- DEPTH, 3, number of entries (1..8).
- BASE_LABEL, 1, label of entry 0; entry i has label BASE_LABEL+i. Requires BASE_LABEL >= 1 and BASE_LABEL+DEPTH-1 <= 15.
- DATA_W, 32, operand/data width.
- LABEL_W, 4, producer tag width; label 0 means "no producer, value valid".
- OP_W, 3, opcode width passed through to the functional unit.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- issue_valid  in  1  dispatcher presents an instruction.
- issue_op  in  OP_W  opcode.
- issue_vj  in  DATA_W  operand j value (meaningful when issue_qj == 0).
- issue_qj  in  LABEL_W  operand j producer label (0 = ready).
- issue_vk  in  DATA_W  operand k value.
- issue_qk  in  LABEL_W  operand k producer label.
- issue_ready  out  1  at least one free entry.
- issue_label  out  LABEL_W  label the incoming instruction will receive; combinational.
- cdb_valid  in  1  CDB broadcast valid this cycle.
- cdb_label  in  LABEL_W  broadcast producer label.
- cdb_data  in  DATA_W  broadcast value.
- fu_valid  out  1  an entry is ready for execution.
- fu_ready  in  1  functional unit accepts.
- fu_op  out  OP_W  opcode of the offered entry.
- fu_a  out  DATA_W  Vj of the offered entry.
- fu_b  out  DATA_W  Vk of the offered entry.
- fu_label  out  LABEL_W  label of the offered entry (tag for the result's CDB request).
- busy_count  out  4  number of occupied entries.

Behaviour:
- Reset (async, rst=1): all entries free; busy_count=0; fu_valid=0; issue_ready=1; issue_label=BASE_LABEL. Stored Vj, Vk, Qj, Qk and op are cleared to 0. Reset mid-operation discards all entries, including one being handshaken.
- Entry state: busy, op, Vj, Qj, Vk, Qk.
- Allocation: the lowest-index free entry. issue_label = BASE_LABEL + that index. When no entry is free, issue_ready=0 and issue_label=0.
- Issue acceptance: issue_valid && issue_ready writes the entry at the next rising edge. issue_valid while issue_ready=0 is ignored, with no state change.
- Issue/CDB bypass: if cdb_valid and issue_qj == cdb_label != 0 in the issue cycle, the entry stores Vj=cdb_data and Qj=0. Same rule for k.
- Wakeup: every cycle with cdb_valid and cdb_label != 0, each busy entry with Qj==cdb_label takes Vj<=cdb_data and Qj<=0; same for k.
  - Both operands may match one broadcast.
  - cdb_label==0 is ignored.
  - A label that matches no entry has no effect.
- Ready: busy && Qj==0 && Qk==0. fu_valid is combinational from registered state, so there is a one-cycle wakeup latency: a CDB capture at edge t gives fu_valid in cycle t+1.
- Selection: the lowest-index ready entry drives fu_op, fu_a, fu_b and fu_label. When fu_valid=0 these outputs are 0.
- Handshake: fu_valid && fu_ready frees the selected entry at that edge.
  - While fu_ready=0, the offered entry and its outputs stay stable unless a lower-index entry becomes ready. Switching to that entry is allowed, since no transfer has occurred.
- Simultaneous free and issue: issue_ready and issue_label reflect pre-edge state, so a slot freed this cycle is allocatable next cycle.
  - Issue and dispatch in the same cycle touch different entries and are both honoured.
- Self-label: an entry never waits on its own label. Qj or Qk equal to the allocated label is a dispatcher error, and behaviour is unspecified.
- busy_count is updated at the same edge as allocation and free (+1, -1, or net 0).

Decomposition:
- Shared package (tomasulo_pkg): DATA_W, LABEL_W, OP_W, LABEL_NONE=0, opcode encodings, per-unit BASE_LABEL constants.
- Sub-module rs_entry: one entry's registers plus write, wakeup, bypass and free logic, exporting ready and busy. It is instantiated DEPTH times.
- The top level holds the two priority encoders (free entry, ready entry), the output mux and busy_count.

Test Plan:
- Issue op=1, vj=5, qj=0, vk=7, qk=0 with fu_ready=1 -> next cycle fu_valid=1, fu_a=5, fu_b=7, fu_label=1; following cycle busy_count=0.
- Issue qj=9, vk=3, then CDB {9, 0x2A} two cycles later -> fu_valid rises the cycle after the broadcast, with fu_a=0x2A, fu_b=3.
- Issue qj=6, qk=6 with a simultaneous CDB {6, 0x11} -> next cycle fu_valid=1, fu_a=fu_b=0x11 (bypass on both operands).
- Fill 3 entries with qj=8 -> issue_ready=0, issue_label=0. A 4th issue is ignored and busy_count stays 3.
- Broadcast {8, 0x55} with fu_ready=1 -> labels 1, 2, 3 dispatch on consecutive cycles in that order. Issue in the cycle label 1 is freed is refused (issue_ready=0) and accepted the next cycle with label 1.
- fu_valid=1, fu_ready=0, assert rst mid-cycle -> fu_valid=0, busy_count=0 immediately, without waiting for a clock edge.
